// File: rtl/present_pkg.sv
// Shared constants, S-box tables and FSM state type
// for the PRESENT-80 decryption key schedule.
package present_pkg;

    localparam int KEY_W      = 80;
    localparam int RK_W       = 64;
    localparam int NUM_ROUNDS = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        EMIT
    } ks_state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/present_inv_key_sched_if.sv
// Load request and round-key stream of the inverse key schedule.
// slave: the key schedule; master: the loader / decrypt datapath.
interface present_inv_key_sched_if;
    import present_pkg::*;

    logic             start;
    logic             key_is_last;
    logic [KEY_W-1:0] key_in;
    logic             busy;
    logic             rk_valid;
    logic             rk_ready;
    logic [RK_W-1:0]  round_key;
    logic [5:0]       rk_idx;
    logic             done;

    modport slave (
        input  start, key_is_last, key_in, rk_ready,
        output busy, rk_valid, round_key, rk_idx, done
    );

    modport master (
        output start, key_is_last, key_in, rk_ready,
        input  busy, rk_valid, round_key, rk_idx, done
    );

endinterface

// File: rtl/present_sbox_inv.sv
// 4-bit combinational PRESENT inverse S-box.
// Ports: x (in nibble), y (Sinv(x)).
module present_sbox_inv
    import present_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y
);

    assign y = SBOX_INV[x];

endmodule

// File: rtl/present_inv_key_sched.sv
// PRESENT-80 decryption key schedule: emits K32..K1 on a valid/ready stream.
// Ports: clk, rst (sync, active-high), ks (slave side of the key-schedule interface).
module present_inv_key_sched
    import present_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    present_inv_key_sched_if.slave    ks
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS + 1);

    ks_state_e        state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [5:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic [KEY_W-1:0] fwd_rot, fwd_k;
    logic [KEY_W-1:0] inv_x, inv_s, inv_k;
    logic [4:0]       inv_c;
    logic [3:0]       inv_nib;

    // Forward step: rotate left 61, S-box top nibble, XOR counter.
    always_comb begin
        fwd_rot         = {key_q[18:0], key_q[79:19]};
        fwd_k           = {sbox(fwd_rot[79:76]), fwd_rot[75:0]};
        fwd_k[19:15]    = fwd_k[19:15] ^ cnt_q;
    end

    // Inverse step undoes the forward step that produced K(idx) from K(idx-1).
    // idx=32 has idx[4:0]=0, so the 5-bit decrement yields 31.
    always_comb begin
        inv_c           = idx_q[4:0] - 5'd1;
        inv_x           = key_q;
        inv_x[19:15]    = key_q[19:15] ^ inv_c;
        inv_s           = {inv_nib, inv_x[75:0]};
        inv_k           = {inv_s[60:0], inv_s[79:61]};
    end

    present_sbox_inv u_sbox_inv (
        .x (inv_x[79:76]),
        .y (inv_nib)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done_q blocks a load in the cycle done is still pulsing
                if (ks.start && !done_q) begin
                    key_d = ks.key_in;
                    if (ks.key_is_last) begin
                        idx_d   = LAST_IDX;
                        state_d = EMIT;
                    end else begin
                        cnt_d   = 5'd1;
                        state_d = FWD;
                    end
                end
            end
            FWD: begin
                key_d = fwd_k;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(NUM_ROUNDS)) begin
                    idx_d   = LAST_IDX;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (ks.rk_ready) begin
                    if (idx_q == 6'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        key_d = inv_k;
                        idx_d = idx_q - 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign ks.busy      = (state_q != IDLE);
    assign ks.rk_valid  = (state_q == EMIT);
    assign ks.round_key = key_q[79:16];
    assign ks.rk_idx    = idx_q;
    assign ks.done      = done_q;

endmodule

// File: tb/tb_present_inv_key_sched.sv
// Directed bench for present_inv_key_sched: table vectors plus
// hand-written sequences for stalls, start filtering and reset abort.
module tb_present_inv_key_sched;

    logic clk;
    logic rst;

    present_inv_key_sched_if bus ();

    present_inv_key_sched dut (
        .clk (clk),
        .rst (rst),
        .ks  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    logic [63:0] exp_rk [1:32];
    logic [63:0] cap [0:2][1:32];
    logic [79:0] k32_zero;
    logic [79:0] scratch;
    logic [95:0] rnd;

    typedef struct {
        string       name;
        int          slot;
        int          idx;
        logic [63:0] rk;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h21748FE3DA09B65C;
        return t[x*4 +: 4];
    endfunction

    // Forward software model: fills exp_rk[1..32], returns K32 state.
    task automatic gen_model(input logic [79:0] key, output logic [79:0] last);
        logic [79:0] k;
        k = key;
        exp_rk[1] = k[79:16];
        for (int i = 1; i <= 31; i++) begin
            k = {k[18:0], k[79:19]};
            k[79:76] = sb(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(i);
            exp_rk[i+1] = k[79:16];
        end
        last = k;
    endtask

    task automatic run_seq(input logic [79:0] key, input logic last,
                           input int rand_ready, input int pulse,
                           input int abort_at, input int exp_lat,
                           input int slot);
        int lat;
        int exp_idx;
        int cyc;
        logic rdy;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.key_is_last = last;
        bus.key_in      = key;
        bus.rk_ready    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.rk_valid && lat < 100) begin
            if (pulse != 0 && lat == 10) begin
                bus.start       = 1'b1;
                bus.key_in      = ~key;
                bus.key_is_last = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk("first_valid_latency", 80'(lat), 80'(exp_lat));
        exp_idx = 32;
        cyc = 0;
        while (exp_idx >= 1 && cyc < 2000) begin
            rdy = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rk_ready = rdy;
            if (pulse != 0 && exp_idx == 20) begin
                bus.start       = 1'b1;
                bus.key_in      = ~key;
                bus.key_is_last = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            chk("rk_valid_high", 80'(bus.rk_valid), 80'(1));
            chk("rk_idx", 80'(bus.rk_idx), 80'(exp_idx));
            chk("round_key", 80'(bus.round_key), 80'(exp_rk[exp_idx]));
            chk("no_early_done", 80'(bus.done), 80'(0));
            if (exp_idx == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                bus.start = 1'b0;
                chk("abort_valid", 80'(bus.rk_valid), 80'(0));
                chk("abort_busy", 80'(bus.busy), 80'(0));
                chk("abort_round_key", 80'(bus.round_key), 80'(0));
                chk("abort_rk_idx", 80'(bus.rk_idx), 80'(0));
                chk("abort_done", 80'(bus.done), 80'(0));
                @(negedge clk);
                chk("abort_no_done", 80'(bus.done), 80'(0));
                chk("abort_idle", 80'(bus.rk_valid), 80'(0));
                return;
            end
            if (rdy && slot >= 0) cap[slot][exp_idx] = bus.round_key;
            @(negedge clk);
            cyc++;
            if (rdy) exp_idx--;
        end
        bus.start    = 1'b0;
        bus.rk_ready = 1'b0;
        chk("all_keys_seen", 80'(exp_idx), 80'(0));
        chk("done_pulse", 80'(bus.done), 80'(1));
        chk("valid_drop", 80'(bus.rk_valid), 80'(0));
        chk("busy_drop", 80'(bus.busy), 80'(0));
        @(negedge clk);
        chk("done_one_cycle", 80'(bus.done), 80'(0));
        chk("stay_idle", 80'(bus.busy), 80'(0));
    endtask

    initial begin
        int cnt;
        n_chk  = 0;
        n_fail = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.key_is_last = 1'b0;
        bus.key_in      = '0;
        bus.rk_ready    = 1'b0;

        tbl[0] = '{"zero_k32", 0, 32, 64'h6dab31744f41d700};
        tbl[1] = '{"zero_k3",  0, 3,  64'h5000180000000001};
        tbl[2] = '{"zero_k2",  0, 2,  64'hc000000000000000};
        tbl[3] = '{"zero_k1",  0, 1,  64'h0000000000000000};
        tbl[4] = '{"ones_k2",  1, 2,  64'h2fffffffffffffff};
        tbl[5] = '{"ones_k1",  1, 1,  64'hffffffffffffffff};

        repeat (3) @(negedge clk);
        chk("reset_busy", 80'(bus.busy), 80'(0));
        chk("reset_valid", 80'(bus.rk_valid), 80'(0));
        chk("reset_done", 80'(bus.done), 80'(0));
        chk("reset_round_key", 80'(bus.round_key), 80'(0));
        chk("reset_rk_idx", 80'(bus.rk_idx), 80'(0));
        rst = 1'b0;

        gen_model(80'h0, k32_zero);
        run_seq(80'h0, 1'b0, 0, 0, 0, 32, 0);

        gen_model({80{1'b1}}, scratch);
        run_seq({80{1'b1}}, 1'b0, 0, 0, 0, 32, 1);

        gen_model(80'h0, scratch);
        run_seq(k32_zero, 1'b1, 0, 0, 0, 1, 2);

        foreach (tbl[i]) begin
            chk(tbl[i].name, 80'(cap[tbl[i].slot][tbl[i].idx]), 80'(tbl[i].rk));
        end
        for (int i = 1; i <= 32; i++) begin
            chk("last_load_same_seq", 80'(cap[2][i]), 80'(cap[0][i]));
        end

        rnd = {$urandom, $urandom, $urandom};
        gen_model(rnd[79:0], scratch);
        run_seq(rnd[79:0], 1'b0, 1, 0, 0, 32, -1);

        gen_model(80'h0123456789abcdef0123, scratch);
        run_seq(80'h0123456789abcdef0123, 1'b0, 0, 1, 0, 32, -1);

        gen_model(80'hfedcba9876543210a5a5, scratch);
        run_seq(80'hfedcba9876543210a5a5, 1'b0, 0, 0, 17, 32, -1);
        run_seq(80'hfedcba9876543210a5a5, 1'b0, 0, 0, 0, 32, -1);

        // start held from the K1 cycle through done
        gen_model(80'h0, scratch);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.key_is_last = 1'b1;
        bus.key_in      = k32_zero;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.rk_ready = 1'b1;
        cnt = 0;
        while (bus.rk_idx != 6'd1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold_reach_k1", 80'(bus.rk_idx), 80'(1));
        bus.start       = 1'b1;
        bus.key_is_last = 1'b0;
        bus.key_in      = {80{1'b1}};
        @(negedge clk);
        chk("hold_done", 80'(bus.done), 80'(1));
        chk("hold_busy_in_done", 80'(bus.busy), 80'(0));
        @(negedge clk);
        chk("hold_ignored_in_done", 80'(bus.busy), 80'(0));
        @(negedge clk);
        chk("hold_loaded_after", 80'(bus.busy), 80'(1));
        bus.start = 1'b0;
        gen_model({80{1'b1}}, scratch);
        cnt = 0;
        while (!bus.rk_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold_first_idx", 80'(bus.rk_idx), 80'(32));
        chk("hold_first_key", 80'(bus.round_key), 80'(exp_rk[32]));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
